// File: rtl/debouncer_multi_if.sv
// debouncer_multi_if
//   Bundles the switch-side signals of debouncer_multi.
//   tick      : sample-enable strobe (tie to 1 for per-clock counting)
//   sw        : raw asynchronous switch inputs, one bit per channel
//   sw_level  : debounced level per channel
//   sw_rise   : one-clk pulse when sw_level goes 0->1
//   sw_fall   : one-clk pulse when sw_level goes 1->0
//   sw_hold   : one-clk long-press pulse (0 unless built with DEBOUNCE_HOLD_EN)
//   master modport: the side driving the switches (board / testbench).
//   slave modport : the debouncer itself.
interface debouncer_multi_if #(
  parameter int unsigned CHANNELS = 3
);
  logic                tick;
  logic [CHANNELS-1:0] sw;
  logic [CHANNELS-1:0] sw_level;
  logic [CHANNELS-1:0] sw_rise;
  logic [CHANNELS-1:0] sw_fall;
  logic [CHANNELS-1:0] sw_hold;

  modport master (
    output tick,
    output sw,
    input  sw_level,
    input  sw_rise,
    input  sw_fall,
    input  sw_hold
  );

  modport slave (
    input  tick,
    input  sw,
    output sw_level,
    output sw_rise,
    output sw_fall,
    output sw_hold
  );
endinterface

// File: rtl/debouncer_multi.sv
// debouncer_multi
//   Debounces CHANNELS independent switch/button inputs. Each channel has a
//   SYNC_STAGES-deep synchroniser followed by a two-state stability FSM that
//   flips the debounced level only after STABLE_CYCLES consecutive qualifying
//   ticks of mismatch; any cycle in which the synchronised input agrees with
//   the level again discards the count (glitch rejection). Rise/fall pulses
//   are registered and coincide with the first cycle of the new level.
//
//   Optional feature, macro DEBOUNCE_HOLD_EN: per-channel long-press counter
//   that emits one sw_hold pulse after HOLD_TICKS ticks of continuous high
//   level. Without the macro sw_hold is tied to 0 and no counter exists.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : debouncer_multi_if.slave (tick, sw in; sw_level, sw_rise,
//            sw_fall, sw_hold out)
module debouncer_multi #(
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter bit          RESET_LEVEL   = 1'b0,
  parameter int unsigned HOLD_TICKS    = 1024
) (
  input  logic               clk,
  input  logic               reset,
  debouncer_multi_if.slave   bus
);

  localparam int unsigned    CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debouncer_multi: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debouncer_multi: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debouncer_multi: STABLE_CYCLES must be >= 2");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("debouncer_multi: HOLD_TICKS must be >= 1");
  end

  typedef enum logic {
    STABLE,
    CHANGING
  } state_e;

  // Synchroniser: stage 0 takes the raw input, stage SYNC_STAGES-1 is s[].
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  s;

  state_e              state_q [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {(SYNC_STAGES * CHANNELS){RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sw};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= {CHANNELS{RESET_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        case (state_q[i])
          STABLE: begin
            // The first mismatching cycle already counts if it carries a tick.
            if (s[i] != level_q[i]) begin
              state_q[i] <= CHANGING;
              if (bus.tick) begin
                cnt_q[i] <= cnt_q[i] + CW'(1);
              end
            end
          end
          CHANGING: begin
            if (s[i] == level_q[i]) begin
              state_q[i] <= STABLE;
              cnt_q[i]   <= '0;
            end else if (bus.tick) begin
              if (cnt_q[i] == CNT_LAST) begin
                level_q[i] <= ~level_q[i];
                rise_q[i]  <= ~level_q[i];
                fall_q[i]  <= level_q[i];
                cnt_q[i]   <= '0;
                state_q[i] <= STABLE;
              end else begin
                cnt_q[i] <= cnt_q[i] + CW'(1);
              end
            end
          end
          default: begin
            state_q[i] <= STABLE;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.sw_level = level_q;
  assign bus.sw_rise  = rise_q;
  assign bus.sw_fall  = fall_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam int unsigned   HW       = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  logic [HW-1:0]       hcnt_q [CHANNELS];
  logic [CHANNELS-1:0] hold_q;

  // Counts on the registered level, so the first increment happens at the
  // end of the sw_rise cycle; saturates at HOLD_MAX until the level drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hcnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= 1'b0;
        if (!level_q[i]) begin
          hcnt_q[i] <= '0;
        end else if (bus.tick && (hcnt_q[i] != HOLD_MAX)) begin
          hcnt_q[i] <= hcnt_q[i] + HW'(1);
          if (hcnt_q[i] == HOLD_MAX - HW'(1)) begin
            hold_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.sw_hold = hold_q;
`else
  assign bus.sw_hold = '0;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi
//   Self-checking bench for debouncer_multi (CHANNELS=3, SYNC_STAGES=2,
//   STABLE_CYCLES=4, RESET_LEVEL=0, HOLD_TICKS=8). A behavioural model
//   (delay queue + per-channel run length of qualifying ticks) is compared
//   against the DUT on every falling edge; directed scenarios add literal
//   expectations, followed by a randomized phase.
module tb_debouncer_multi;

  localparam int unsigned CH = 3;
  localparam int unsigned SS = 2;
  localparam int unsigned SC = 4;
  localparam int unsigned HT = 8;
  localparam bit          RL = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  debouncer_multi_if #(.CHANNELS(CH)) bus ();

  debouncer_multi #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC),
    .RESET_LEVEL  (RL),
    .HOLD_TICKS   (HT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm, input logic [CH-1:0] act,
                              input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_level, m_rise, m_fall, m_hold;
  int            run[CH];
`ifdef DEBOUNCE_HOLD_EN
  int            held[CH];
`endif
  bit            model_ready = 1'b0;

  always @(posedge clk) begin : model
    logic [CH-1:0] s_now;
    if (reset) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back({CH{RL}});
      m_level = {CH{RL}};
      m_rise  = '0;
      m_fall  = '0;
      m_hold  = '0;
      for (int c = 0; c < CH; c++) begin
        run[c] = 0;
`ifdef DEBOUNCE_HOLD_EN
        held[c] = 0;
`endif
      end
      model_ready = 1'b1;
    end else if (model_ready) begin
      s_now  = hist[0];
      m_rise = '0;
      m_fall = '0;
      m_hold = '0;
      for (int c = 0; c < CH; c++) begin
`ifdef DEBOUNCE_HOLD_EN
        if (!m_level[c]) held[c] = 0;
        else if (bus.tick && held[c] < HT) begin
          held[c]++;
          if (held[c] == HT) m_hold[c] = 1'b1;
        end
`endif
        if (s_now[c] == m_level[c]) run[c] = 0;
        else if (bus.tick) begin
          run[c]++;
          if (run[c] == SC) begin
            run[c]     = 0;
            m_level[c] = ~m_level[c];
            if (m_level[c]) m_rise[c] = 1'b1;
            else            m_fall[c] = 1'b1;
          end
        end
      end
      void'(hist.pop_front());
      hist.push_back(bus.sw);
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("model_level", bus.sw_level, m_level);
      chk("model_rise",  bus.sw_rise,  m_rise);
      chk("model_fall",  bus.sw_fall,  m_fall);
      chk("model_hold",  bus.sw_hold,  m_hold);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input logic [CH-1:0] want, input string nm);
    int n = 0;
    while (bus.sw_level !== want && n < 40) begin
      step(1);
      n++;
    end
    chk(nm, bus.sw_level, want);
  endtask

  initial begin
    bus.sw   = '0;
    bus.tick = 1'b1;
    reset    = 1'b1;
    step(3);
    chk("reset_level", bus.sw_level, 3'b000);
    chk("reset_rise",  bus.sw_rise,  3'b000);
    chk("reset_fall",  bus.sw_fall,  3'b000);
    chk("reset_hold",  bus.sw_hold,  3'b000);
    reset = 1'b0;
    step(2);

    // clean press on channel 0
    bus.sw = 3'b001;
    step(5);
    chk("press_level_e5", bus.sw_level, 3'b000);
    chk("press_rise_e5",  bus.sw_rise,  3'b000);
    step(1);
    chk("press_level_e6", bus.sw_level, 3'b001);
    chk("press_rise_e6",  bus.sw_rise,  3'b001);
    chk("press_fall_e6",  bus.sw_fall,  3'b000);
    step(1);
    chk("press_rise_e7",  bus.sw_rise,  3'b000);

    // bounce on channel 1: 1,0,1,0 each for 2 clocks, then held high
    for (int k = 0; k < 4; k++) begin
      bus.sw[1] = (k % 2 == 0);
      for (int j = 0; j < 2; j++) begin
        step(1);
        chk("bounce_rise",  bus.sw_rise,  3'b000);
        chk("bounce_level", bus.sw_level, 3'b001);
      end
    end
    bus.sw[1] = 1'b1;
    step(5);
    chk("bounce_level_e5", bus.sw_level, 3'b001);
    step(1);
    chk("bounce_level_e6", bus.sw_level, 3'b011);
    chk("bounce_rise_e6",  bus.sw_rise,  3'b010);
    step(1);
    chk("bounce_rise_e7",  bus.sw_rise,  3'b000);

    // all high, then simultaneous release
    bus.sw = 3'b111;
    wait_level(3'b111, "all_high");
    step(2);
    bus.sw = 3'b000;
    step(5);
    chk("release_level_e5", bus.sw_level, 3'b111);
    chk("release_fall_e5",  bus.sw_fall,  3'b000);
    step(1);
    chk("release_fall_e6",  bus.sw_fall,  3'b111);
    chk("release_level_e6", bus.sw_level, 3'b000);
    chk("release_rise_e6",  bus.sw_rise,  3'b000);
    step(1);
    chk("release_fall_e7",  bus.sw_fall,  3'b000);

    // strobed tick every 4th clock, channel 2 pressed on a tick cycle
    for (int k = 0; k <= 16; k++) begin
      bus.tick = (k % 4 == 0);
      if (k == 0) bus.sw[2] = 1'b1;
      step(1);
      if (k == 15) chk("strobe_level_e16", bus.sw_level, 3'b000);
      if (k == 16) begin
        chk("strobe_level_e17", bus.sw_level, 3'b100);
        chk("strobe_rise_e17",  bus.sw_rise,  3'b100);
      end
    end
    bus.tick = 1'b1;
    bus.sw   = 3'b000;
    wait_level(3'b000, "strobe_release");
    step(2);

    // reset in the middle of a count
    bus.sw = 3'b001;
    step(4);
    reset = 1'b1;
    step(2);
    chk("midreset_level", bus.sw_level, 3'b000);
    chk("midreset_rise",  bus.sw_rise,  3'b000);
    reset = 1'b0;
    step(5);
    chk("postreset_level_e5", bus.sw_level, 3'b000);
    chk("postreset_rise_e5",  bus.sw_rise,  3'b000);
    step(1);
    chk("postreset_level_e6", bus.sw_level, 3'b001);
    chk("postreset_rise_e6",  bus.sw_rise,  3'b001);

`ifdef DEBOUNCE_HOLD_EN
    // currently in the sw_rise cycle of channel 0
    step(7);
    chk("hold_e7", bus.sw_hold, 3'b000);
    step(1);
    chk("hold_e8", bus.sw_hold, 3'b001);
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("hold_norepeat", bus.sw_hold, 3'b000);
    end
    bus.sw = 3'b000;
    wait_level(3'b000, "hold_release");
    bus.sw = 3'b001;
    begin
      int n = 0;
      while (bus.sw_rise !== 3'b001 && n < 40) begin
        step(1);
        n++;
      end
      chk("hold_repress_rise", bus.sw_rise, 3'b001);
    end
    step(7);
    chk("hold2_e7", bus.sw_hold, 3'b000);
    step(1);
    chk("hold2_e8", bus.sw_hold, 3'b001);
`else
    step(20);
    chk("hold_disabled", bus.sw_hold, 3'b000);
`endif

    // randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) bus.sw[c] = ~bus.sw[c];
      end
      bus.tick = (cyc < 1500) ? 1'b1 : ($urandom_range(0, 2) != 0);
      reset    = ($urandom_range(0, 599) == 0);
      step(1);
    end
    reset    = 1'b0;
    bus.tick = 1'b1;
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
